// File: rtl/layernorm_stats.sv
`default_nettype none
// ============================================================================
// layernorm_stats : streaming mean / clamped variance of N-element Q8.8 vectors
// Rev 1.0
// ============================================================================
module layernorm_stats #(
   parameter int N         = 64,
   parameter int VAR_SHIFT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x_in,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] mean,
   output logic [15:0] var_q16,
   output logic        len_err
);

   localparam int LOG2N = $clog2(N);
   localparam int SUM_W = 16 + LOG2N;
   localparam int SQ_W  = 32 + LOG2N;
   localparam logic [LOG2N-1:0] c_last_idx = LOG2N'(N - 1);

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                  state_q;
   logic [LOG2N-1:0]        cnt_q;
   logic signed [SUM_W-1:0] sum_q;
   logic [SQ_W-1:0]         sumsq_q;
   logic [15:0]             mean_q;
   logic [15:0]             var_q16_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic                    len_err_q;

   logic                    w_beat;
   logic                    w_at_last;
   logic signed [31:0]      w_sq_s;
   logic signed [15:0]      w_mean;
   logic signed [31:0]      w_msq_s;
   logic [31:0]             w_ex2;
   logic [31:0]             w_var;
   logic [31:0]             w_var_sh;
   logic [15:0]             w_var_q16;

   assign w_beat    = in_valid && in_ready_q;
   assign w_at_last = (cnt_q == c_last_idx);
   assign w_sq_s    = $signed(x_in) * $signed(x_in);

   // Dividing by N is a shift; taking the upper slice is the floor toward -inf.
   assign w_mean    = sum_q[LOG2N +: 16];
   assign w_ex2     = sumsq_q[LOG2N +: 32];
   assign w_msq_s   = w_mean * w_mean;
   assign w_var     = (w_ex2 >= $unsigned(w_msq_s)) ? (w_ex2 - $unsigned(w_msq_s)) : 32'd0;
   assign w_var_sh  = w_var >> VAR_SHIFT;
   assign w_var_q16 = (|w_var_sh[31:16]) ? 16'hFFFF : w_var_sh[15:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         cnt_q       <= '0;
         sum_q       <= '0;
         sumsq_q     <= '0;
         mean_q      <= '0;
         var_q16_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         len_err_q <= 1'b0;
         case (state_q)
            ACC: begin
               if (w_beat) begin
                  sum_q     <= sum_q + SUM_W'($signed(x_in));
                  sumsq_q   <= sumsq_q + SQ_W'($unsigned(w_sq_s));
                  // in_last is only a cross-check; cnt alone frames the vector.
                  len_err_q <= in_last ^ w_at_last;
                  if (w_at_last) begin
                     cnt_q      <= '0;
                     in_ready_q <= 1'b0;
                     state_q    <= CALC;
                  end else begin
                     cnt_q <= cnt_q + LOG2N'(1);
                  end
               end
            end
            CALC: begin
               mean_q      <= w_mean;
               var_q16_q   <= w_var_q16;
               out_valid_q <= 1'b1;
               state_q     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  sum_q       <= '0;
                  sumsq_q     <= '0;
                  cnt_q       <= '0;
                  state_q     <= ACC;
               end
            end
            default: begin
               state_q     <= ACC;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign mean      = mean_q;
   assign var_q16   = var_q16_q;
   assign len_err   = len_err_q;

endmodule
`default_nettype wire
